// File: rtl/type_classifier_pkg.sv
// Shared record layout, class constants and output-entry format for type_classifier.
package type_classifier_pkg;

  localparam int WIDTH_RECORD = 45;
  localparam int SRC_MSB      = 44;
  localparam int SRC_LSB      = 42;
  localparam int PKT_MSB      = 41;
  localparam int PKT_LSB      = 32;
  localparam int KEY_MSB      = 31;

  localparam int WIDTH_SRC    = SRC_MSB - SRC_LSB + 1;
  localparam int WIDTH_PKT    = PKT_MSB - PKT_LSB + 1;

  localparam int                     WIDTH_CLASS   = 4;
  localparam logic [WIDTH_CLASS-1:0] DEFAULT_CLASS = 4'hF;

  typedef struct packed {
    logic [WIDTH_CLASS-1:0] cls;
    logic                   hit;
    logic [WIDTH_SRC-1:0]   src;
    logic [WIDTH_PKT-1:0]   pkt;
  } out_entry_t;

  localparam int WIDTH_ENTRY = $bits(out_entry_t);

endpackage

// File: rtl/type_classifier_out_fifo.sv
// Show-ahead output FIFO; when empty the head port replays the most recently popped entry.
module classifier_out_fifo
  import type_classifier_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH_ENTRY-1:0] din_i,
  input  logic                   pop_i,
  output logic [WIDTH_ENTRY-1:0] dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   push_ok_o
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH_ENTRY-1:0] mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [AW-1:0]          last_ptr;
  logic [AW:0]            count_q;
  logic                   pop_ok;

  assign full_o    = (count_q == CNT_MAX);
  assign empty_o   = (count_q == '0);
  assign pop_ok    = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok_o = push_i & (~full_o | pop_ok);

  // The slot behind the read pointer is never rewritten while empty.
  assign last_ptr = rd_ptr_q - PTR_ONE;
  assign dout_o   = empty_o ? mem_q[last_ptr] : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok_o) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_ok_o, pop_ok})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/type_classifier.sv
// Header classifier: value/mask rule match, 3-stage pipeline, buffered valid/ready output.
// Optional per-class hit counters built when CLASSIFIER_STATS_EN is defined.
module type_classifier
  import type_classifier_pkg::*;
#(
  parameter int NUM_RULES = 8,
  parameter int WIDTH_KEY = 32,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH_RECORD-1:0]      type_in,
  input  logic                         type_in_valid,
  input  logic                         cfg_wr,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_addr,
  input  logic [WIDTH_KEY-1:0]         cfg_value,
  input  logic [WIDTH_KEY-1:0]         cfg_mask,
  input  logic [WIDTH_CLASS-1:0]       cfg_class,
  input  logic                         cfg_enable,
  output logic                         class_out_valid,
  input  logic                         class_out_ready,
  output logic [WIDTH_CLASS-1:0]       class_out,
  output logic                         class_hit,
  output logic [WIDTH_SRC-1:0]         class_src,
  output logic [WIDTH_PKT-1:0]         class_pkt,
  output logic [15:0]                  drop_cnt,
  input  logic [WIDTH_CLASS-1:0]       stat_sel,
  output logic [15:0]                  stat_cnt
);

  localparam int RULE_AW = $clog2(NUM_RULES);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [RULE_AW-1:0] first_hit(input logic [NUM_RULES-1:0] m);
    first_hit = '0;
    for (int r = NUM_RULES - 1; r >= 0; r--) begin
      if (m[r]) first_hit = RULE_AW'(r);
    end
  endfunction

  logic [WIDTH_KEY-1:0]   value_q [NUM_RULES];
  logic [WIDTH_KEY-1:0]   mask_q  [NUM_RULES];
  logic [WIDTH_CLASS-1:0] cls_q   [NUM_RULES];
  logic [NUM_RULES-1:0]   en_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '0;
      for (int r = 0; r < NUM_RULES; r++) begin
        value_q[r] <= '0;
        mask_q[r]  <= '0;
        cls_q[r]   <= '0;
      end
    end else if (cfg_wr) begin
      value_q[cfg_addr] <= cfg_value;
      mask_q[cfg_addr]  <= cfg_mask;
      cls_q[cfg_addr]   <= cfg_class;
      en_q[cfg_addr]    <= cfg_enable;
    end
  end

  // ---- S1: input record register
  logic                    vld_p1;
  logic [WIDTH_RECORD-1:0] rec_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= type_in_valid;
  end

  always_ff @(posedge clk) begin
    if (type_in_valid) rec_p1 <= type_in;
  end

  logic [WIDTH_KEY-1:0] key_p1;
  logic [NUM_RULES-1:0] match_d;

  assign key_p1 = rec_p1[KEY_MSB:0];

  always_comb begin
    match_d = '0;
    for (int r = 0; r < NUM_RULES; r++) begin
      match_d[r] = en_q[r] & (((key_p1 ^ value_q[r]) & mask_q[r]) == '0);
    end
  end

  // ---- S2: match vector plus class snapshot, so a later rule write cannot alter this record
  logic                   vld_p2;
  logic [NUM_RULES-1:0]   match_p2;
  logic [WIDTH_CLASS-1:0] cls_p2 [NUM_RULES];
  logic [WIDTH_SRC-1:0]   src_p2;
  logic [WIDTH_PKT-1:0]   pkt_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      match_p2 <= match_d;
      src_p2   <= rec_p1[SRC_MSB:SRC_LSB];
      pkt_p2   <= rec_p1[PKT_MSB:PKT_LSB];
      for (int r = 0; r < NUM_RULES; r++) cls_p2[r] <= cls_q[r];
    end
  end

  // ---- S3: priority encode and push into the output FIFO
  out_entry_t             push_entry;
  logic [RULE_AW-1:0]     hit_idx;
  logic                   push_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [WIDTH_ENTRY-1:0] fifo_dout;
  out_entry_t             head;

  assign hit_idx = first_hit(match_p2);

  always_comb begin
    push_entry.hit = |match_p2;
    push_entry.cls = push_entry.hit ? cls_p2[hit_idx] : DEFAULT_CLASS;
    push_entry.src = src_p2;
    push_entry.pkt = pkt_p2;
  end

  classifier_out_fifo #(
    .DEPTH(OUT_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push_i   (vld_p2),
    .din_i    (push_entry),
    .pop_i    (class_out_ready),
    .dout_o   (fifo_dout),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .push_ok_o(push_ok)
  );

  assign head            = out_entry_t'(fifo_dout);
  assign class_out_valid = ~fifo_empty;
  assign class_out       = head.cls;
  assign class_hit       = head.hit;
  assign class_src       = head.src;
  assign class_pkt       = head.pkt;

  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                drop_cnt_q <= '0;
    else if (vld_p2 & fifo_full & ~push_ok)    drop_cnt_q <= sat_inc16(drop_cnt_q);
  end

  assign drop_cnt = drop_cnt_q;

`ifdef CLASSIFIER_STATS_EN
  logic [15:0] hit_cnt_q [2**WIDTH_CLASS];
  logic [15:0] stat_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_cnt_q <= '0;
      for (int c = 0; c < 2**WIDTH_CLASS; c++) hit_cnt_q[c] <= '0;
    end else begin
      if (push_ok) hit_cnt_q[push_entry.cls] <= sat_inc16(hit_cnt_q[push_entry.cls]);
      stat_cnt_q <= hit_cnt_q[stat_sel];
    end
  end

  assign stat_cnt = stat_cnt_q;
`else
  assign stat_cnt = {{(16 - WIDTH_CLASS){1'b0}}, stat_sel & {WIDTH_CLASS{1'b0}}};
`endif

endmodule

// File: tb/tb_type_classifier.sv
// Directed bench for type_classifier with a queue-based reference model and per-cycle compare.
module tb_type_classifier;

  logic        clk = 1'b0;
  logic        reset;
  logic [44:0] type_in;
  logic        type_in_valid;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_value;
  logic [31:0] cfg_mask;
  logic [3:0]  cfg_class;
  logic        cfg_enable;
  logic        class_out_valid;
  logic        class_out_ready;
  logic [3:0]  class_out;
  logic        class_hit;
  logic [2:0]  class_src;
  logic [9:0]  class_pkt;
  logic [15:0] drop_cnt;
  logic [3:0]  stat_sel;
  logic [15:0] stat_cnt;

  type_classifier dut (
    .clk            (clk),
    .reset          (reset),
    .type_in        (type_in),
    .type_in_valid  (type_in_valid),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_value      (cfg_value),
    .cfg_mask       (cfg_mask),
    .cfg_class      (cfg_class),
    .cfg_enable     (cfg_enable),
    .class_out_valid(class_out_valid),
    .class_out_ready(class_out_ready),
    .class_out      (class_out),
    .class_hit      (class_hit),
    .class_src      (class_src),
    .class_pkt      (class_pkt),
    .drop_cnt       (drop_cnt),
    .stat_sel       (stat_sel),
    .stat_cnt       (stat_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n9    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: rule table, two-record delay, FIFO as a queue of {class,hit,src,pkt}.
  logic [31:0] m_val  [8];
  logic [31:0] m_mask [8];
  logic [3:0]  m_cls  [8];
  logic [7:0]  m_en = '0;
  logic [17:0] mq[$];
  logic [17:0] last_e = '0;
  logic [17:0] p1e = '0, p2e = '0;
  bit          p1v = 0, p2v = 0, m_pop;
  int          drop_exp = 0;
  int          cnt[16];
  int          stat_exp = 0;

  function automatic logic [17:0] classify(input logic [44:0] rec);
    for (int r = 0; r < 8; r++) begin
      if (m_en[r] && (((rec[31:0] ^ m_val[r]) & m_mask[r]) == 32'd0))
        return {m_cls[r], 1'b1, rec[44:32]};
    end
    return {4'hF, 1'b0, rec[44:32]};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_en = '0;
      for (int r = 0; r < 8; r++) begin
        m_val[r] = '0; m_mask[r] = '0; m_cls[r] = '0;
      end
      mq.delete();
      last_e = '0; p1v = 0; p2v = 0; drop_exp = 0; stat_exp = 0;
      for (int c = 0; c < 16; c++) cnt[c] = 0;
    end else begin
      stat_exp = cnt[stat_sel];
      m_pop = (mq.size() > 0) && class_out_ready;
      if (m_pop) begin
        last_e = mq[0];
        void'(mq.pop_front());
      end
      if (p2v) begin
        if (mq.size() < 4) begin
          mq.push_back(p2e);
          if (cnt[p2e[17:14]] < 65535) cnt[p2e[17:14]]++;
        end else if (drop_exp < 65535) begin
          drop_exp++;
        end
      end
      p2v = p1v;
      p2e = p1e;
      if (cfg_wr) begin
        m_val[cfg_addr]  = cfg_value;
        m_mask[cfg_addr] = cfg_mask;
        m_cls[cfg_addr]  = cfg_class;
        m_en[cfg_addr]   = cfg_enable;
      end
      p1v = type_in_valid;
      if (type_in_valid) p1e = classify(type_in);
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {63'd0, class_out_valid}, {63'd0, mq.size() > 0});
    chk("out_entry", {46'd0, class_out, class_hit, class_src, class_pkt},
        {46'd0, (mq.size() > 0) ? mq[0] : last_e});
    chk("drop_cnt", {48'd0, drop_cnt}, 64'(drop_exp));
`ifdef CLASSIFIER_STATS_EN
    chk("stat_cnt", {48'd0, stat_cnt}, 64'(stat_exp));
`else
    chk("stat_cnt", {48'd0, stat_cnt}, 64'd0);
`endif
  end

  always @(posedge clk) begin
    if (reset && class_out_valid && class_out_ready && class_out == 4'd9) n9++;
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [31:0] v, input logic [31:0] m,
                     input logic [3:0] c, input logic e);
    cfg_addr = a; cfg_value = v; cfg_mask = m; cfg_class = c; cfg_enable = e;
    cfg_wr = 1'b1;
    cyc();
    cfg_wr = 1'b0;
  endtask

  task automatic send(input logic [44:0] rec);
    type_in = rec;
    type_in_valid = 1'b1;
    cyc();
    type_in_valid = 1'b0;
  endtask

  task automatic send_chk(input string name, input logic [44:0] rec,
                          input logic [3:0] ec, input logic eh);
    send(rec);
    cyc();
    cyc();
    chk({name, "_valid"}, {63'd0, class_out_valid}, 64'd1);
    chk({name, "_class"}, {60'd0, class_out}, {60'd0, ec});
    chk({name, "_hit"},   {63'd0, class_hit}, {63'd0, eh});
    chk({name, "_srcpkt"}, {51'd0, class_src, class_pkt}, {51'd0, rec[44:32]});
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; type_in = '0; type_in_valid = 1'b0; cfg_wr = 1'b0; cfg_addr = '0;
    cfg_value = '0; cfg_mask = '0; cfg_class = '0; cfg_enable = 1'b0;
    class_out_ready = 1'b1; stat_sel = 4'd0;
    #2 reset = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", {63'd0, class_out_valid}, 64'd0);
    chk("rst_class", {60'd0, class_out}, 64'd0);
    chk("rst_drop",  {48'd0, drop_cnt}, 64'd0);
    chk("rst_stat",  {48'd0, stat_cnt}, 64'd0);
    reset = 1'b1;
    cyc();

    // Basic match with latency pinned
    cfg(3'd0, 32'h0800_0000, 32'hFFFF_0000, 4'd2, 1'b1);
    send({3'd5, 10'd17, 32'h0800_1234});
    cyc();
    chk("lat_early", {63'd0, class_out_valid}, 64'd0);
    cyc();
    chk("basic_valid", {63'd0, class_out_valid}, 64'd1);
    chk("basic_class", {60'd0, class_out}, 64'd2);
    chk("basic_hit",   {63'd0, class_hit}, 64'd1);
    chk("basic_src",   {61'd0, class_src}, 64'd5);
    chk("basic_pkt",   {54'd0, class_pkt}, 64'd17);
    cyc();

    // Priority and miss
    cfg(3'd1, 32'h0, 32'h0, 4'd7, 1'b1);
    send_chk("prio0", {3'd1, 10'd2, 32'h0800_0001}, 4'd2, 1'b1);
    send_chk("prio1", {3'd2, 10'd3, 32'h86DD_0000}, 4'd7, 1'b1);
    cfg(3'd1, 32'h0, 32'h0, 4'd7, 1'b0);
    send_chk("miss",  {3'd3, 10'd4, 32'h86DD_0000}, 4'hF, 1'b0);

    // Backpressure: 6 records into 4 slots
    class_out_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      send({3'(i), 10'(100 + i), (i % 2 == 1) ? 32'h86DD_0000 : 32'h0800_00AA});
    repeat (4) cyc();
    chk("bp_drop",  {48'd0, drop_cnt}, 64'd2);
    chk("bp_valid", {63'd0, class_out_valid}, 64'd1);
    chk("bp_hold",  {54'd0, class_pkt}, 64'd100);
    class_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_pkt",   {54'd0, class_pkt}, 64'(100 + i));
      chk("bp_class", {60'd0, class_out}, (i % 2 == 1) ? 64'hF : 64'd2);
      cyc();
    end
    chk("bp_empty", {63'd0, class_out_valid}, 64'd0);
    chk("bp_last",  {54'd0, class_pkt}, 64'd103);

    // Full FIFO with a pop on the push edge
    class_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send({3'd1, 10'(200 + i), 32'h0800_0BEE});
    repeat (3) cyc();
    send({3'd2, 10'd204, 32'h1234_5678});
    cyc();
    class_out_ready = 1'b1;
    cyc();
    class_out_ready = 1'b0;
    chk("fullpop_drop", {48'd0, drop_cnt}, 64'd2);
    chk("fullpop_head", {54'd0, class_pkt}, 64'd201);
    class_out_ready = 1'b1;
    repeat (6) cyc();
    chk("fullpop_last", {54'd0, class_pkt}, 64'd204);

    // Rule rewrite during traffic
    stat_sel = 4'd9;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        cfg_addr = 3'd0; cfg_value = 32'h0800_0000; cfg_mask = 32'hFFFF_0000;
        cfg_class = 4'd9; cfg_enable = 1'b1; cfg_wr = 1'b1;
      end
      send({3'd4, 10'(300 + i), 32'h0800_0005});
      cfg_wr = 1'b0;
    end
    repeat (6) cyc();
    chk("cfg_n9", 64'(n9), 64'd5);
`ifdef CLASSIFIER_STATS_EN
    chk("cfg_stat9", {48'd0, stat_cnt}, 64'd5);
`endif

    // Reset with records in flight
    for (int i = 0; i < 3; i++) send({3'd6, 10'(400 + i), 32'h0800_0001});
    #2 reset = 1'b0;
    cyc();
    chk("mrst_valid", {63'd0, class_out_valid}, 64'd0);
    chk("mrst_data",  {46'd0, class_out, class_hit, class_src, class_pkt}, 64'd0);
    chk("mrst_drop",  {48'd0, drop_cnt}, 64'd0);
    reset = 1'b1;
    repeat (5) cyc();
    chk("mrst_quiet", {63'd0, class_out_valid}, 64'd0);
    chk("mrst_drop2", {48'd0, drop_cnt}, 64'd0);
    send_chk("mrst_rules", {3'd7, 10'd500, 32'h0800_1234}, 4'hF, 1'b0);

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
